led_scan_driver: RTL



---
 rtl/led_scan_driver_pkg.sv | 39 +++
 rtl/led_scan_driver_scan_slot_timer.sv | 55 +++++
 rtl/led_scan_driver.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/led_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// led_scan_driver_pkg
//
// Shared definitions for the LED digit scanner:
//   - default geometry and timing of the scan (digit count, slot length,
//     dark gap at the start of every slot)
//   - the scanner state encoding
//   - a helper giving the idle (all digits dark) level of the digit selects
// ---------------------------------------------------------------------------
package led_scan_driver_pkg;

    // Default number of display positions.
    localparam int DEFAULT_DIGITS         = 8;

    // Default clock cycles per digit slot, dark gap included.
    localparam int DEFAULT_SCAN_DIV       = 50000;

    // Default dark cycles at the start of every slot (anti-ghosting gap).
    localparam int DEFAULT_DEAD_CYCLES    = 100;

    // Default select polarity: 1 = common-anode driver, selects active-low.
    localparam int DEFAULT_SEL_ACTIVE_LOW = 1;

    // Scanner states.
    //   IDLE : display off, waiting for enable
    //   DEAD : dark gap at the start of a slot, all selects inactive
    //   ON   : current digit lit (unless blanked)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } scan_state_e;

    // Level that turns a digit select off for the given polarity.
    function automatic logic sel_inactive_level(input int active_low);
        return (active_low != 0);
    endfunction

endpackage

// File: rtl/led_scan_driver_scan_slot_timer.sv
// ---------------------------------------------------------------------------
// scan_slot_timer
//
// Slot-position counter for the LED scanner. Counts clock cycles within one
// digit slot and flags the last dark cycle and the last cycle of the slot.
// The counter wraps to zero by itself at the end of every slot, so the
// scanner only has to hold it clear while it is idle or disabled.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous clear; counter is forced to 0 on the next edge
//   dead_done  out  counter is on the last cycle of the dark gap
//   slot_done  out  counter is on the last cycle of the slot
// ---------------------------------------------------------------------------
module scan_slot_timer #(
    parameter int SCAN_DIV    = 8,
    parameter int DEAD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic dead_done,
    output logic slot_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    assign dead_done = (div_cnt_q == DEAD_LAST);
    assign slot_done = (div_cnt_q == SLOT_LAST);

    // Free-running within a slot; wraps at the slot boundary so the next
    // slot starts its dark gap at count 0 without help from the scanner.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (clear || slot_done) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/led_scan_driver.sv
// ---------------------------------------------------------------------------
// led_scan_driver
//
// Time-multiplexing scanner that sits directly in front of the seven-segment
// encoder. At the start of every frame it captures a snapshot of all digit
// nibbles plus their dot and blank flags, then walks through the digits one
// slot at a time. Each slot begins with a dark gap (all selects off) to stop
// ghosting, after which the digit's common-anode select is driven for the
// rest of the slot. The nibble and dot request for the encoder come only
// from the snapshot registers, so they move at slot boundaries and never
// follow glitches on the live inputs.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   scan enable; low blanks the display and idles the scan
//   display_data  in   DIGITS nibbles, nibble i at [4i+3:4i], digit 0 rightmost
//   dot_mask      in   bit i lights the dot of digit i
//   blank_mask    in   bit i keeps digit i dark
//   bcd_data      out  nibble of the current digit for the encoder
//   need_dot      out  dot request of the current digit for the encoder
//   digit_sel     out  one-hot digit select, polarity set by SEL_ACTIVE_LOW
//   frame_start   out  one-cycle pulse on the cycle after a snapshot is taken
// ---------------------------------------------------------------------------
module led_scan_driver
    import led_scan_driver_pkg::*;
#(
    parameter int DIGITS         = DEFAULT_DIGITS,
    parameter int SCAN_DIV       = DEFAULT_SCAN_DIV,
    parameter int DEAD_CYCLES    = DEFAULT_DEAD_CYCLES,
    parameter int SEL_ACTIVE_LOW = DEFAULT_SEL_ACTIVE_LOW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   display_data,
    input  logic [DIGITS-1:0]     dot_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [3:0]            bcd_data,
    output logic                  need_dot,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_start
);

    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{sel_inactive_level(SEL_ACTIVE_LOW)}};

    scan_state_e          state_q;
    scan_state_e          state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [4*DIGITS-1:0]  snap_data_q;
    logic [4*DIGITS-1:0]  snap_data_d;
    logic [DIGITS-1:0]    snap_dot_q;
    logic [DIGITS-1:0]    snap_dot_d;
    logic [DIGITS-1:0]    snap_blank_q;
    logic [DIGITS-1:0]    snap_blank_d;
    logic [DIGITS-1:0]    digit_sel_q;
    logic [DIGITS-1:0]    digit_sel_d;
    logic                 frame_start_q;
    logic                 frame_start_d;

    logic                 load_snap;
    logic [DIGITS-1:0]    sel_onehot;
    logic [DIGITS-1:0]    sel_active;
    logic                 timer_clear;
    logic                 dead_done;
    logic                 slot_done;

    // The slot counter only runs while a scan is in progress; holding it
    // clear in IDLE (or when disabled) makes every new frame start at count 0.
    assign timer_clear = !enable || (state_q == IDLE);

    scan_slot_timer #(
        .SCAN_DIV    (SCAN_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_slot_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (timer_clear),
        .dead_done (dead_done),
        .slot_done (slot_done)
    );

    // Select pattern for the current digit in the output polarity.
    assign sel_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
    assign sel_active = (SEL_ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;

    // Next-state logic. A snapshot is taken when leaving IDLE and when the
    // last digit's slot ends; both cases also restart at digit 0 and raise
    // frame_start for one cycle. digit_sel defaults to off and is only held
    // on through the lit part of a slot.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        snap_data_d   = snap_data_q;
        snap_dot_d    = snap_dot_q;
        snap_blank_d  = snap_blank_q;
        digit_sel_d   = SEL_OFF;
        frame_start_d = 1'b0;
        load_snap     = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = DEAD;
                    idx_d     = '0;
                    load_snap = 1'b1;
                end
                DEAD: begin
                    if (dead_done) begin
                        state_d = ON;
                        if (!snap_blank_q[idx_q]) begin
                            digit_sel_d = sel_active;
                        end
                    end
                end
                ON: begin
                    if (slot_done) begin
                        state_d = DEAD;
                        if (idx_q == IDX_LAST) begin
                            idx_d     = '0;
                            load_snap = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        digit_sel_d = digit_sel_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end

        if (load_snap) begin
            snap_data_d   = display_data;
            snap_dot_d    = dot_mask;
            snap_blank_d  = blank_mask;
            frame_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            snap_data_q   <= '0;
            snap_dot_q    <= '0;
            snap_blank_q  <= '0;
            digit_sel_q   <= SEL_OFF;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            snap_data_q   <= snap_data_d;
            snap_dot_q    <= snap_dot_d;
            snap_blank_q  <= snap_blank_d;
            digit_sel_q   <= digit_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Encoder feed comes from registers only, so it cannot glitch with the
    // live inputs and only moves when idx or the snapshot changes.
    assign bcd_data    = snap_data_q[{idx_q, 2'b00} +: 4];
    assign need_dot    = snap_dot_q[idx_q];
    assign digit_sel   = digit_sel_q;
    assign frame_start = frame_start_q;

endmodule
